layer_ctrl: RTL and testbench

- Control unit for a fully-connected layer_M_N_P_T datapath.
- Accepts N input words on a valid/ready slave stream and sequences the input-memory writes.
- Drives input-memory and weight-ROM read addresses and P parallel MAC lanes over M/P rounds.
- Emits the P lane results per round on a valid/ready master stream by steering the output mux.
- Owns no arithmetic; the datapath holds the memories, MACs, ReLU and mux.

---
 rtl/layer_pkg.sv | 33 +++
 rtl/layer_ctr.sv | 28 ++
 rtl/layer_ctrl.sv | 157 +++++++++++++++
 tb/tb_layer_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared types and elaboration-time helpers for the fully-connected layer controller.
package layer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        OUTPUT
    } state_t;

    // Width of a counter/address that must index `count` distinct values (never below 1 bit).
    function automatic int ctr_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    function automatic int rounds(input int m, input int p);
        return m / p;
    endfunction

    function automatic int x_addr_width(input int n);
        return ctr_width(n);
    endfunction

    function automatic int w_addr_width(input int m, input int n, input int p);
        return ctr_width(rounds(m, p) * n);
    endfunction

    function automatic int out_sel_width(input int p);
        return ctr_width(p);
    endfunction

endpackage

// File: rtl/layer_ctr.sv
// Terminal-count counter: counts 0..COUNT-1 and returns to 0 when enabled at the last value.
module layer_ctr
    import layer_pkg::*;
#(
    parameter int COUNT = 2,
    localparam int W = ctr_width(COUNT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == W'(COUNT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/layer_ctrl.sv
// Sequencer for a layer_M_N_P_T datapath: loads N inputs, runs M/P MAC rounds of N cycles,
// then streams the P lane results of each round through the output mux.
module layer_ctrl
    import layer_pkg::*;
#(
    parameter int M = 5,
    parameter int N = 2,
    parameter int P = 1,
    parameter int T = 9,
    localparam int ROUNDS = rounds(M, P),
    localparam int XAW    = x_addr_width(N),
    localparam int WAW    = w_addr_width(M, N, P),
    localparam int OSW    = out_sel_width(P),
    localparam int RW     = ctr_width(ROUNDS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    output logic           s_ready,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           x_we,
    output logic [XAW-1:0] x_addr,
    output logic [WAW-1:0] w_addr,
    output logic           mac_en,
    output logic           mac_first,
    output logic [OSW-1:0] out_sel
);

    if (T < 1 || N < 1 || P < 1 || M < P || (M % P) != 0) begin : g_param_check
        $error("layer_ctrl: illegal parameter set");
    end

    state_t state;
    state_t next_state;

    logic [XAW-1:0] k_cnt;
    logic [RW-1:0]  r_cnt;
    logic [OSW-1:0] lane_cnt;
    logic           k_max;
    logic           r_max;
    logic           lane_max;
    logic           k_en;
    logic           r_en;
    logic           lane_en;
    logic           ctr_clr;

    layer_ctr #(.COUNT(N)) u_k_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clr),
        .en     (k_en),
        .count  (k_cnt),
        .at_max (k_max)
    );

    layer_ctr #(.COUNT(ROUNDS)) u_r_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clr),
        .en     (r_en),
        .count  (r_cnt),
        .at_max (r_max)
    );

    layer_ctr #(.COUNT(P)) u_lane_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clr),
        .en     (lane_en),
        .count  (lane_cnt),
        .at_max (lane_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counters return to 0 on their own at terminal count, so only IDLE needs an explicit clear.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        x_we       = 1'b0;
        x_addr     = '0;
        w_addr     = '0;
        out_sel    = '0;
        k_en       = 1'b0;
        r_en       = 1'b0;
        lane_en    = 1'b0;
        ctr_clr    = 1'b0;

        case (state)
            IDLE: begin
                ctr_clr    = 1'b1;
                next_state = LOAD;
            end

            LOAD: begin
                s_ready = 1'b1;
                x_addr  = k_cnt;
                if (s_valid) begin
                    x_we = 1'b1;
                    k_en = 1'b1;
                    if (k_max) begin
                        next_state = COMPUTE;
                    end
                end
            end

            COMPUTE: begin
                x_addr = k_cnt;
                w_addr = WAW'(int'(r_cnt) * N + int'(k_cnt));
                k_en   = 1'b1;
                if (k_max) begin
                    next_state = DRAIN;
                end
            end

            DRAIN: begin
                next_state = OUTPUT;
            end

            OUTPUT: begin
                m_valid = 1'b1;
                out_sel = lane_cnt;
                if (m_ready) begin
                    lane_en = 1'b1;
                    if (lane_max) begin
                        r_en       = 1'b1;
                        next_state = r_max ? LOAD : COMPUTE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Memory reads take one cycle, so MAC strobes trail the COMPUTE address phase by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
        end else begin
            mac_en    <= (state == COMPUTE);
            mac_first <= (state == COMPUTE) && (k_cnt == '0);
        end
    end

endmodule

// File: tb/tb_layer_ctrl.sv
// Directed self-checking bench for layer_ctrl: cycle-exact sequences for two configurations,
// stalls, sparse input, mid-round reset and a long randomised handshake run.
module tb_layer_ctrl;

    logic       clk = 1'b0;
    logic       reset1, s_valid1, m_ready1;
    logic       s_ready1, m_valid1, x_we1, mac_en1, mac_first1;
    logic [0:0] x_addr1;
    logic [3:0] w_addr1;
    logic [0:0] out_sel1;

    logic       reset2, s_valid2, m_ready2;
    logic       s_ready2, m_valid2, x_we2, mac_en2, mac_first2;
    logic [1:0] x_addr2;
    logic [2:0] w_addr2;
    logic [0:0] out_sel2;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    int cstart[5];
    int hs_end[5];
    int stall_lo;
    int stall_hi;

    always #5 clk = ~clk;

    layer_ctrl #(.M(5), .N(2), .P(1), .T(9)) dut1 (
        .clk       (clk),
        .reset     (reset1),
        .s_valid   (s_valid1),
        .s_ready   (s_ready1),
        .m_valid   (m_valid1),
        .m_ready   (m_ready1),
        .x_we      (x_we1),
        .x_addr    (x_addr1),
        .w_addr    (w_addr1),
        .mac_en    (mac_en1),
        .mac_first (mac_first1),
        .out_sel   (out_sel1)
    );

    layer_ctrl #(.M(4), .N(3), .P(2), .T(9)) dut2 (
        .clk       (clk),
        .reset     (reset2),
        .s_valid   (s_valid2),
        .s_ready   (s_ready2),
        .m_valid   (m_valid2),
        .m_ready   (m_ready2),
        .x_we      (x_we2),
        .x_addr    (x_addr2),
        .w_addr    (w_addr2),
        .mac_en    (mac_en2),
        .mac_first (mac_first2),
        .out_sel   (out_sel2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int e_sr, input int e_mv, input int e_we,
                            input int e_xa, input int e_wa, input int e_me, input int e_mf, input int e_os);
        checkOutput({tag, " s_ready"},   32'(s_ready1),   32'(e_sr));
        checkOutput({tag, " m_valid"},   32'(m_valid1),   32'(e_mv));
        checkOutput({tag, " x_we"},      32'(x_we1),      32'(e_we));
        checkOutput({tag, " x_addr"},    32'(x_addr1),    32'(e_xa));
        checkOutput({tag, " w_addr"},    32'(w_addr1),    32'(e_wa));
        checkOutput({tag, " mac_en"},    32'(mac_en1),    32'(e_me));
        checkOutput({tag, " mac_first"}, 32'(mac_first1), 32'(e_mf));
        checkOutput({tag, " out_sel"},   32'(out_sel1),   32'(e_os));
    endtask

    task automatic applyStimulus(input logic sv, input logic mr);
        s_valid1 = sv;
        m_ready1 = mr;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic release1();
        @(negedge clk);
        reset1 = 1'b1;
        cyc    = 0;
    endtask

    // Walks dut1 (M=5,N=2,P=1) from cycle 0 to last_cycle against the round schedule in cstart/hs_end.
    task automatic runPlain(input string name, input int last_cycle);
        int reload;
        reload = hs_end[4] + 1;
        for (int c = 0; c <= last_cycle; c++) begin
            int e_sr, e_mv, e_xa, e_wa, e_me, e_mf;
            applyStimulus(1'b1, !(c >= stall_lo && c <= stall_hi));
            e_sr = (c == 1 || c == 2 || c == reload) ? 1 : 0;
            e_xa = (c == 2) ? 1 : 0;
            e_mv = 0; e_wa = 0; e_me = 0; e_mf = 0;
            for (int r = 0; r < 5; r++) begin
                if (c == cstart[r]) e_wa = 2 * r;
                if (c == cstart[r] + 1) begin
                    e_wa = 2 * r + 1;
                    e_xa = 1;
                    e_mf = 1;
                end
                if (c == cstart[r] + 1 || c == cstart[r] + 2) e_me = 1;
                if (c >= cstart[r] + 3 && c <= hs_end[r]) e_mv = 1;
            end
            checkAll($sformatf("%s c%0d", name, c), e_sr, e_mv, e_sr, e_xa, e_wa, e_me, e_mf, 0);
            if (c < last_cycle) next_cycle();
        end
    endtask

    initial begin
        int acc, hs, budget, overlap, unstable, prev_stall, prev_sel;
        bit timed_out;

        reset1 = 1'b0; s_valid1 = 1'b1; m_ready1 = 1'b1;
        reset2 = 1'b0; s_valid2 = 1'b1; m_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAll("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] nominal sequence, s_valid and m_ready high");
        release1();
        cstart = '{3, 7, 11, 15, 19};
        hs_end = '{6, 10, 14, 18, 22};
        stall_lo = 100; stall_hi = -1;
        runPlain("nominal", 23);

        $display("[TB] output stall of 3 cycles in round 0");
        reset1 = 1'b0; #1;
        release1();
        cstart = '{3, 10, 14, 18, 22};
        hs_end = '{9, 13, 17, 21, 25};
        stall_lo = 6; stall_hi = 8;
        runPlain("stall", 26);

        $display("[TB] sparse s_valid 1,0,0,1");
        reset1 = 1'b0; #1;
        release1();
        applyStimulus(1'b0, 1'b1); checkAll("sparse c0", 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); applyStimulus(1'b1, 1'b1); checkAll("sparse c1", 1, 0, 1, 0, 0, 0, 0, 0);
        next_cycle(); applyStimulus(1'b0, 1'b1); checkAll("sparse c2", 1, 0, 0, 1, 0, 0, 0, 0);
        next_cycle(); applyStimulus(1'b0, 1'b1); checkAll("sparse c3", 1, 0, 0, 1, 0, 0, 0, 0);
        next_cycle(); applyStimulus(1'b1, 1'b1); checkAll("sparse c4", 1, 0, 1, 1, 0, 0, 0, 0);
        next_cycle(); applyStimulus(1'b0, 1'b1); checkAll("sparse c5", 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); applyStimulus(1'b0, 1'b1); checkAll("sparse c6", 0, 0, 0, 1, 1, 1, 1, 0);

        $display("[TB] reset asserted in DRAIN of round 2");
        reset1 = 1'b0; #1;
        release1();
        cstart = '{3, 7, 11, 15, 19};
        hs_end = '{6, 10, 14, 18, 22};
        stall_lo = 100; stall_hi = -1;
        runPlain("pre_reset", 13);
        reset1 = 1'b0;
        #1;
        checkAll("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        checkAll("held_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        release1();
        runPlain("post_reset", 23);

        $display("[TB] M=4 N=3 P=2 configuration");
        @(negedge clk);
        reset2 = 1'b1;
        hs = 0;
        for (int c = 0; c <= 16; c++) begin
            int e_sr, e_mv, e_os, e_wa, e_xa, e_mf;
            #1;
            e_sr = (c >= 1 && c <= 3) || c == 16;
            e_mv = (c == 8 || c == 9 || c == 14 || c == 15);
            e_os = (c == 9 || c == 15);
            e_wa = (c >= 4 && c <= 6) ? c - 4 : (c >= 10 && c <= 12) ? c - 7 : 0;
            e_xa = (c >= 1 && c <= 3) ? c - 1 : (c >= 4 && c <= 6) ? c - 4 : (c >= 10 && c <= 12) ? c - 10 : 0;
            e_mf = (c == 5 || c == 11);
            checkOutput($sformatf("p2 c%0d s_ready", c),   32'(s_ready2),   32'(e_sr));
            checkOutput($sformatf("p2 c%0d m_valid", c),   32'(m_valid2),   32'(e_mv));
            checkOutput($sformatf("p2 c%0d out_sel", c),   32'(out_sel2),   32'(e_os));
            checkOutput($sformatf("p2 c%0d w_addr", c),    32'(w_addr2),    32'(e_wa));
            checkOutput($sformatf("p2 c%0d x_addr", c),    32'(x_addr2),    32'(e_xa));
            checkOutput($sformatf("p2 c%0d mac_first", c), 32'(mac_first2), 32'(e_mf));
            if (m_valid2 && m_ready2) hs++;
            @(posedge clk);
        end
        checkOutput("p2 handshakes", 32'(hs), 32'd4);

        $display("[TB] randomised back-to-back vectors");
        reset1 = 1'b0; #1;
        release1();
        overlap = 0; unstable = 0; prev_stall = 0; prev_sel = 0; timed_out = 1'b0;
        for (int v = 0; v < 1000; v++) begin
            acc = 0; hs = 0; budget = 0;
            while (hs < 5 && budget < 400) begin
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
                if (s_valid1 && s_ready1) acc++;
                if (m_valid1 && m_ready1) hs++;
                if (s_ready1 && m_valid1) overlap++;
                if (prev_stall != 0 && (m_valid1 !== 1'b1 || int'(out_sel1) != prev_sel)) unstable++;
                prev_stall = (m_valid1 && !m_ready1) ? 1 : 0;
                prev_sel   = int'(out_sel1);
                next_cycle();
                budget++;
            end
            checkOutput($sformatf("rand v%0d handshakes", v), 32'(hs), 32'd5);
            checkOutput($sformatf("rand v%0d accepts", v), 32'(acc), 32'd2);
            if (hs != 5) begin
                timed_out = 1'b1;
                break;
            end
        end
        checkOutput("rand timeout", 32'(timed_out), 32'd0);
        checkOutput("rand overlap", 32'(overlap), 32'd0);
        checkOutput("rand stall_stability", 32'(unstable), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
